// File: rtl/uart_packet_deframer.sv
// uart_packet_deframer: strips 0x7E/0x7D byte-stuffed framing from the rx fifo
// stream and emits payload beats with last/err marking plus good/bad frame counters.
//
// Optional feature: define UART_DEFRAMER_CHECKSUM_EN to treat the final byte of each
// frame as an 8-bit additive checksum (hold depth 2); undefined gives hold depth 1.
//
// Ports:
//   clk, reset             clock; asynchronous active-high reset
//   fifo_data, fifo_empty  show-ahead head of the rx fifo
//   fifo_read_enable       combinational pop of the head byte
//   out_data/out_valid/out_ready/out_last/out_err  payload stream
//   good_count             frames closed without error (wraps)
//   err_count              frames closed with error (saturates at 255)
module uart_packet_deframer #(
    parameter int MAX_LEN  = 256,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          fifo_data,
    input  logic                fifo_empty,
    output logic                fifo_read_enable,
    output logic [7:0]          out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                out_err,
    output logic [CNT_BITS-1:0] good_count,
    output logic [7:0]          err_count
);

`ifdef UART_DEFRAMER_CHECKSUM_EN
    localparam int H  = 2;
    localparam bit CK = 1'b1;
`else
    localparam int H  = 1;
    localparam bit CK = 1'b0;
`endif

    localparam int             LW    = $clog2(MAX_LEN + H + 1);
    localparam logic [LW-1:0]  LIMIT = LW'(MAX_LEN + H - 1);
    localparam logic [1:0]     HC    = 2'(H);
    localparam logic [7:0]     FLAG  = 8'h7E;
    localparam logic [7:0]     ESCB  = 8'h7D;

    typedef enum logic [1:0] {HUNT, START, DATA, ESC} state_t;

    state_t        state, state_n;
    logic [7:0]    hold0, hold0_n;
    logic [7:0]    hold1, hold1_n;
    logic [1:0]    held, held_n;
    logic [LW-1:0] len, len_n, len_inc;
    logic [7:0]    sum, sum_n;
    logic          push;
    logic [7:0]    push_val;
    logic          beat, beat_last, beat_err;
    logic          is_flag, is_esc;

    assign fifo_read_enable = !fifo_empty && (!out_valid || out_ready);
    assign is_flag = (fifo_data == FLAG);
    assign is_esc  = (fifo_data == ESCB);

    always_comb begin
        state_n   = state;
        hold0_n   = hold0;
        hold1_n   = hold1;
        held_n    = held;
        len_n     = len;
        sum_n     = sum;
        push      = 1'b0;
        push_val  = fifo_data;
        len_inc   = len + LW'(1);
        beat      = 1'b0;
        beat_last = 1'b0;
        beat_err  = 1'b0;

        if (fifo_read_enable) begin
            unique case (state)
                HUNT: begin
                    if (is_flag) state_n = START;
                end
                START, DATA: begin
                    if (is_flag) begin
                        // Close: in START nothing is held, so this is a no-op.
                        if (held == HC) begin
                            beat      = 1'b1;
                            beat_last = 1'b1;
                            beat_err  = CK && (sum != 8'h00);
                        end
                        held_n  = '0;
                        len_n   = '0;
                        sum_n   = '0;
                        state_n = START;
                    end else if (is_esc) begin
                        state_n = ESC;
                    end else begin
                        push = 1'b1;
                    end
                end
                ESC: begin
                    if (is_flag) begin
                        // Abort: flush the oldest held byte as a failed frame.
                        if (held != 2'd0) begin
                            beat      = 1'b1;
                            beat_last = 1'b1;
                            beat_err  = 1'b1;
                        end
                        held_n  = '0;
                        len_n   = '0;
                        sum_n   = '0;
                        state_n = START;
                    end else begin
                        push     = 1'b1;
                        push_val = fifo_data ^ 8'h20;
                    end
                end
                default: state_n = HUNT;
            endcase
        end

        if (push) begin
            sum_n   = sum + push_val;
            len_n   = len_inc;
            state_n = DATA;
            if (len_inc > LIMIT) begin
                // Overflow: terminate with error, discard until next flag.
                beat      = 1'b1;
                beat_last = 1'b1;
                beat_err  = 1'b1;
                held_n    = '0;
                len_n     = '0;
                sum_n     = '0;
                state_n   = HUNT;
            end else if (held == HC) begin
                beat = 1'b1;
                if (H == 2) begin
                    hold0_n = hold1;
                    hold1_n = push_val;
                end else begin
                    hold0_n = push_val;
                end
            end else begin
                held_n = held + 2'd1;
                if (held == 2'd0) hold0_n = push_val;
                else              hold1_n = push_val;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= HUNT;
            hold0      <= '0;
            hold1      <= '0;
            held       <= '0;
            len        <= '0;
            sum        <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_err    <= 1'b0;
            good_count <= '0;
            err_count  <= '0;
        end else begin
            state <= state_n;
            hold0 <= hold0_n;
            hold1 <= hold1_n;
            held  <= held_n;
            len   <= len_n;
            sum   <= sum_n;
            if (beat) begin
                out_valid <= 1'b1;
                out_data  <= hold0;
                out_last  <= beat_last;
                out_err   <= beat_err;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (beat && beat_last) begin
                if (beat_err) begin
                    if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                end else begin
                    good_count <= good_count + CNT_BITS'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_packet_deframer.sv
// tb_uart_packet_deframer: directed bench for uart_packet_deframer with a
// show-ahead fifo model and a beat capture log; DUT built with MAX_LEN=4.
module tb_uart_packet_deframer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  fifo_data;
    logic        fifo_empty;
    logic        fifo_read_enable;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        out_err;
    logic [15:0] good_count;
    logic [7:0]  err_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem [0:255];
    logic [7:0] wr_ptr = '0;
    logic [7:0] rd_ptr = '0;
    logic [9:0] cap [0:63];
    int         cap_n = 0;

    always #5 clk = ~clk;

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_data  = mem[rd_ptr];

    always @(posedge clk)
        if (fifo_read_enable) rd_ptr <= rd_ptr + 8'd1;

    always @(posedge clk)
        if (!reset && out_valid && out_ready) begin
            cap[cap_n] = {out_last, out_err, out_data};
            cap_n++;
        end

    uart_packet_deframer #(.MAX_LEN(4), .CNT_BITS(16)) dut (
        .clk(clk),
        .reset(reset),
        .fifo_data(fifo_data),
        .fifo_empty(fifo_empty),
        .fifo_read_enable(fifo_read_enable),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last(out_last),
        .out_err(out_err),
        .good_count(good_count),
        .err_count(err_count)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic put(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic drain(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rd_ptr == wr_ptr && !out_valid) begin
                done = 1'b1;
                break;
            end
        end
        @(negedge clk);
        check(tag, done, 1);
    endtask

    // beat word = {last, err, data}
    task automatic beat(input string tag, input int idx, input logic [9:0] exp);
        check(tag, cap[idx], exp);
    endtask

    initial begin
        reset     = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_valid", out_valid, 0);
        check("rst_good", good_count, 0);
        check("rst_err", err_count, 0);
        check("rst_rden", fifo_read_enable, 0);

        // Repeated flags: nothing emitted.
        put(8'h7E); put(8'h7E); put(8'h7E);
        drain("t6a_drain");
        check("t6a_beats", cap_n, 0);

        // Partial frame then reset while downstream stalls.
        out_ready = 1'b0;
        put(8'h7E); put(8'h01); put(8'h02);
        repeat (6) @(negedge clk);
        check("t6b_rden", fifo_read_enable, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("t6b_valid", out_valid, 0);
        check("t6b_beats", cap_n, 0);
        check("t6b_good", good_count, 0);
        check("t6b_err", err_count, 0);

`ifdef UART_DEFRAMER_CHECKSUM_EN
        put(8'h7E); put(8'h01); put(8'h02); put(8'hFD); put(8'h7E);
        drain("t2a_drain");
        check("t2a_n", cap_n, 2);
        beat("t2a_b0", 0, 10'h001);
        beat("t2a_b1", 1, 10'h202);
        check("t2a_good", good_count, 1);

        put(8'h7E); put(8'h01); put(8'h02); put(8'hFC); put(8'h7E);
        drain("t2b_drain");
        check("t2b_n", cap_n, 4);
        beat("t2b_b0", 2, 10'h001);
        beat("t2b_b1", 3, 10'h302);
        check("t2b_good", good_count, 1);
        check("t2b_err", err_count, 1);

        put(8'h7E); put(8'h05); put(8'h7E);
        drain("t2c_drain");
        check("t2c_n", cap_n, 4);
        check("t2c_good", good_count, 1);
        check("t2c_err", err_count, 1);
`else
        // Test 1: leading junk in HUNT, escaped flag in payload.
        put(8'h55); put(8'h7E); put(8'h01); put(8'h7D);
        put(8'h5E); put(8'h02); put(8'h7E);
        drain("t1_drain");
        check("t1_n", cap_n, 3);
        beat("t1_b0", 0, 10'h001);
        beat("t1_b1", 1, 10'h07E);
        beat("t1_b2", 2, 10'h202);
        check("t1_good", good_count, 1);
        check("t1_err", err_count, 0);

        // Test 3: abort then a good frame.
        put(8'h7E); put(8'h01); put(8'h02); put(8'h7D);
        put(8'h7E); put(8'h03); put(8'h7E);
        drain("t3_drain");
        check("t3_n", cap_n, 6);
        beat("t3_b0", 3, 10'h001);
        beat("t3_b1", 4, 10'h302);
        beat("t3_b2", 5, 10'h203);
        check("t3_good", good_count, 2);
        check("t3_err", err_count, 1);

        // Test 4: overflow at MAX_LEN=4.
        put(8'h7E);
        for (int i = 1; i <= 6; i++) put(8'(i));
        put(8'h7E); put(8'h09); put(8'h7E);
        drain("t4_drain");
        check("t4_n", cap_n, 11);
        beat("t4_b0", 6, 10'h001);
        beat("t4_b1", 7, 10'h002);
        beat("t4_b2", 8, 10'h003);
        beat("t4_b3", 9, 10'h304);
        beat("t4_b4", 10, 10'h209);
        check("t4_good", good_count, 3);
        check("t4_err", err_count, 2);

        // Abort with nothing held: dropped silently.
        put(8'h7E); put(8'h7D); put(8'h7E);
        drain("tab_drain");
        check("tab_n", cap_n, 11);
        check("tab_err", err_count, 2);

        // Test 5: backpressure mid-frame.
        out_ready = 1'b0;
        put(8'h7E); put(8'h11); put(8'h22); put(8'h33); put(8'h7E);
        for (int i = 0; i < 20; i++) begin
            if (out_valid) break;
            @(negedge clk);
        end
        check("t5_wait", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t5_rden", fifo_read_enable, 0);
            check("t5_hold", {out_valid, out_last, out_data}, 10'h211);
        end
        out_ready = 1'b1;
        drain("t5_drain");
        check("t5_n", cap_n, 14);
        beat("t5_b0", 11, 10'h011);
        beat("t5_b1", 12, 10'h022);
        beat("t5_b2", 13, 10'h233);
        check("t5_good", good_count, 4);
        check("t5_err", err_count, 2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
